// File: rtl/pwm_cmd_if.sv
// Command and PWM output bundle between the SPI word receiver and pwm_cmd_engine.
// cmd_valid is a single-cycle strobe qualifying cmd_data; there is no ready, every strobed word is consumed.
interface pwm_cmd_if #(
   parameter int NCH = 3
);
   logic            cmd_valid;
   logic [31:0]     cmd_data;
   logic [NCH-1:0]  pwm_out;
   logic            period_start;
   logic            cmd_err;

   modport master (
      output cmd_valid,
      output cmd_data,
      input  pwm_out,
      input  period_start,
      input  cmd_err
   );

   modport slave (
      input  cmd_valid,
      input  cmd_data,
      output pwm_out,
      output period_start,
      output cmd_err
   );
endinterface

// File: rtl/pwm_cmd_engine.sv
// Register-write decoder feeding a three-channel PWM with a shared prescaled period counter.
// Duty and period are double-buffered and only take effect at a period boundary or on a sync command.
module pwm_cmd_engine #(
   parameter int WIDTH = 8,
   parameter int NCH   = 3
) (
   input logic         clk,
   input logic         rst,
   pwm_cmd_if.slave    bus
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [NCH-1:0][WIDTH-1:0] duty_q, duty_d;
   logic [NCH-1:0][WIDTH-1:0] duty_sh_q, duty_sh_d;
   logic [WIDTH-1:0]          period_q, period_d;
   logic [WIDTH-1:0]          period_sh_q, period_sh_d;
   logic [WIDTH-1:0]          presc_q, presc_d;
   logic [WIDTH-1:0]          pcnt_q, pcnt_d;
   logic [WIDTH-1:0]          cnt_q, cnt_d;
   logic [NCH-1:0]            en_q, en_d;
   logic [NCH-1:0]            pol_q, pol_d;
   logic [NCH-1:0]            pwm_q, pwm_d;
   logic                      sync_q, sync_d;
   logic                      zero_q, zero_d;
   logic                      period_start_q, period_start_d;
   logic                      cmd_err_q, cmd_err_d;

   logic [3:0]                addr;
   logic [WIDTH-1:0]          wdata;
   logic                      tick;
   logic                      wrap;
   logic                      unused_cmd_bits;

   assign addr            = bus.cmd_data[31:28];
   assign wdata           = bus.cmd_data[WIDTH-1:0];
   assign unused_cmd_bits = ^bus.cmd_data[27:WIDTH];
   assign tick            = (pcnt_q == presc_q);
   assign wrap            = tick && (cnt_q == period_sh_q);

   always_comb begin
      duty_d         = duty_q;
      duty_sh_d      = duty_sh_q;
      period_d       = period_q;
      period_sh_d    = period_sh_q;
      presc_d        = presc_q;
      pcnt_d         = pcnt_q;
      cnt_d          = cnt_q;
      en_d           = en_q;
      pol_d          = pol_q;
      pwm_d          = pwm_q;
      sync_d         = 1'b0;
      zero_d         = 1'b0;
      period_start_d = zero_q;
      cmd_err_d      = 1'b0;

      // A pending sync restarts the period exactly like a wrap, regardless of the prescaler phase.
      if (sync_q || wrap) begin
         cnt_d       = '0;
         pcnt_d      = '0;
         duty_sh_d   = duty_q;
         period_sh_d = period_q;
         zero_d      = 1'b1;
      end else if (tick) begin
         pcnt_d = '0;
         cnt_d  = cnt_q + ONE;
      end else begin
         pcnt_d = pcnt_q + ONE;
      end

      for (int i = 0; i < NCH; i++) begin
         pwm_d[i] = en_q[i] ? ((cnt_q < duty_sh_q[i]) ^ pol_q[i]) : pol_q[i];
      end

      // Register writes land after the counter update so a prescaler write wins the pcnt clear.
      if (bus.cmd_valid) begin
         case (addr)
            4'h0:    duty_d[0] = wdata;
            4'h1:    duty_d[1] = wdata;
            4'h2:    duty_d[2] = wdata;
            4'h3:    period_d  = wdata;
            4'h4: begin
               presc_d = wdata;
               pcnt_d  = '0;
            end
            4'h5:    en_d      = wdata[NCH-1:0];
            4'h6:    pol_d     = wdata[NCH-1:0];
            4'h7:    sync_d    = 1'b1;
            default: cmd_err_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_q         <= '0;
         duty_sh_q      <= '0;
         period_q       <= '1;
         period_sh_q    <= '1;
         presc_q        <= '0;
         pcnt_q         <= '0;
         cnt_q          <= '0;
         en_q           <= '0;
         pol_q          <= '0;
         pwm_q          <= '0;
         sync_q         <= 1'b0;
         zero_q         <= 1'b0;
         period_start_q <= 1'b0;
         cmd_err_q      <= 1'b0;
      end else begin
         duty_q         <= duty_d;
         duty_sh_q      <= duty_sh_d;
         period_q       <= period_d;
         period_sh_q    <= period_sh_d;
         presc_q        <= presc_d;
         pcnt_q         <= pcnt_d;
         cnt_q          <= cnt_d;
         en_q           <= en_d;
         pol_q          <= pol_d;
         pwm_q          <= pwm_d;
         sync_q         <= sync_d;
         zero_q         <= zero_d;
         period_start_q <= period_start_d;
         cmd_err_q      <= cmd_err_d;
      end
   end

   assign bus.pwm_out      = pwm_q;
   assign bus.period_start = period_start_q;
   assign bus.cmd_err      = cmd_err_q;

endmodule

// File: tb/tb_pwm_cmd_engine.sv
// Directed and randomized checks of pwm_cmd_engine against a per-cycle reference model
// plus whole-period high-count measurements.
module tb_pwm_cmd_engine;
   localparam int W   = 8;
   localparam int NCH = 3;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   pwm_cmd_if #(.NCH(NCH)) bus ();

   pwm_cmd_engine #(.WIDTH(W), .NCH(NCH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [W-1:0]   m_duty [NCH];
   logic [W-1:0]   m_dsh  [NCH];
   logic [W-1:0]   m_p, m_psh, m_s, m_cnt, m_pcnt;
   logic [NCH-1:0] m_en, m_pol;
   logic           m_sync, m_zero;
   logic [NCH-1:0] exp_pwm;
   logic           exp_ps, exp_err;

   int meas_hi [NCH];
   int meas_ps;
   int meas_found;

   function automatic logic [31:0] mk(input int a, input int d);
      logic [3:0] av;
      logic [7:0] dv;
      av = a[3:0];
      dv = d[7:0];
      return {av, 20'h0, dv};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_duty[i] = '0;
         m_dsh[i]  = '0;
      end
      m_p = '1; m_psh = '1; m_s = '0; m_cnt = '0; m_pcnt = '0;
      m_en = '0; m_pol = '0; m_sync = 1'b0; m_zero = 1'b0;
      exp_pwm = '0; exp_ps = 1'b0; exp_err = 1'b0;
   endtask

   // One clock of the rules: outputs reflect the previous count; a period restarts on sync or
   // when the last tick of the period ends; writes apply after the count update.
   task automatic model_step(input logic v, input logic [31:0] d);
      logic [3:0] a;
      logic [7:0] x;
      a = d[31:28];
      x = d[7:0];
      for (int i = 0; i < NCH; i++)
         exp_pwm[i] = m_en[i] ? ((m_cnt < m_dsh[i]) ^ m_pol[i]) : m_pol[i];
      exp_ps  = m_zero;
      exp_err = v && (a >= 4'd8);
      m_zero  = 1'b0;
      if (m_sync || (m_pcnt == m_s && m_cnt == m_psh)) begin
         m_cnt = '0; m_pcnt = '0; m_dsh = m_duty; m_psh = m_p; m_zero = 1'b1;
      end else if (m_pcnt == m_s) begin
         m_pcnt = '0;
         m_cnt  = m_cnt + 8'd1;
      end else begin
         m_pcnt = m_pcnt + 8'd1;
      end
      m_sync = 1'b0;
      if (v) begin
         case (a)
            4'h0, 4'h1, 4'h2: m_duty[a] = x;
            4'h3: m_p = x;
            4'h4: begin m_s = x; m_pcnt = '0; end
            4'h5: m_en  = x[NCH-1:0];
            4'h6: m_pol = x[NCH-1:0];
            4'h7: m_sync = 1'b1;
            default: ;
         endcase
      end
   endtask

   task automatic check_outputs();
      check("pwm_out", 32'(bus.pwm_out), 32'(exp_pwm));
      check("period_start", 32'(bus.period_start), 32'(exp_ps));
      check("cmd_err", 32'(bus.cmd_err), 32'(exp_err));
   endtask

   task automatic cyc(input logic v, input logic [31:0] d);
      bus.cmd_valid = v;
      bus.cmd_data  = d;
      @(posedge clk);
      if (rst) model_reset();
      else     model_step(v, d);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic wr(input int a, input int d);
      cyc(1'b1, mk(a, d));
   endtask

   task automatic wait_ps();
      meas_found = 0;
      for (int k = 0; k < 600; k++) begin
         if (bus.period_start === 1'b1) begin
            meas_found = 1;
            break;
         end
         cyc(1'b0, 32'h0);
      end
      check("period_start_seen", 32'(meas_found), 32'd1);
   endtask

   task automatic measure(input int len);
      wait_ps();
      for (int i = 0; i < NCH; i++) meas_hi[i] = 0;
      meas_ps = 0;
      for (int j = 0; j < len; j++) begin
         for (int i = 0; i < NCH; i++) meas_hi[i] += int'(bus.pwm_out[i]);
         meas_ps += int'(bus.period_start);
         cyc(1'b0, 32'h0);
      end
   endtask

   initial begin
      int hi;
      int ones;
      logic v;
      int a;
      int d;

      rst = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = 32'h0;
      model_reset();
      @(negedge clk);
      cyc(1'b0, 32'h0);
      cyc(1'b0, 32'h0);
      rst = 1'b0;
      cyc(1'b0, 32'h0);

      // basic period: P=9, duty0=3, channel 0 only, then sync
      wr(3, 9); wr(4, 0); wr(0, 3); wr(5, 1); wr(7, 0);
      cyc(1'b0, 32'h0);
      check("sync_ps_early", 32'(bus.period_start), 32'd0);
      cyc(1'b0, 32'h0);
      check("sync_ps_3clk", 32'(bus.period_start), 32'd1);
      check("sync_first_high", 32'(bus.pwm_out[0]), 32'd1);
      measure(20);
      check("p9_hi0", 32'(meas_hi[0]), 32'd6);
      check("p9_ps", 32'(meas_ps), 32'd2);
      check("p9_hi12", 32'(meas_hi[1] + meas_hi[2]), 32'd0);

      // duty boundaries: 0 stays inactive, duty above P stays active
      wr(1, 0); wr(2, 10); wr(5, 7); wr(7, 0);
      measure(10);
      check("duty0_const_low", 32'(meas_hi[1]), 32'd0);
      check("dutybig_const_high", 32'(meas_hi[2]), 32'd10);
      check("ch0_still3", 32'(meas_hi[0]), 32'd3);

      // mid-period duty change only shows from the next period
      wait_ps();
      hi = 0;
      for (int j = 0; j < 10; j++) begin
         hi += int'(bus.pwm_out[0]);
         if (j == 4) wr(0, 7);
         else        cyc(1'b0, 32'h0);
      end
      check("midwrite_cur", 32'(hi), 32'd3);
      measure(10);
      check("midwrite_next", 32'(meas_hi[0]), 32'd7);
      check("midwrite_ps", 32'(meas_ps), 32'd1);

      // prescaler S=1, P=3, duty0=2: 8 clk period, 4 high
      wr(4, 1); wr(3, 3); wr(0, 2); wr(7, 0);
      measure(16);
      check("presc_hi0", 32'(meas_hi[0]), 32'd8);
      check("presc_ps", 32'(meas_ps), 32'd2);
      check("presc_hi2", 32'(meas_hi[2]), 32'd16);

      // unmapped address: error pulse, nothing else moves
      cyc(1'b1, 32'hA000_0055);
      check("err_pulse", 32'(bus.cmd_err), 32'd1);
      cyc(1'b0, 32'h0);
      check("err_clear", 32'(bus.cmd_err), 32'd0);
      measure(16);
      check("after_err_hi0", 32'(meas_hi[0]), 32'd8);
      check("after_err_ps", 32'(meas_ps), 32'd2);
      wr(6, 1);
      measure(16);
      check("pol_hi0", 32'(meas_hi[0]), 32'd8);
      check("pol_hi2", 32'(meas_hi[2]), 32'd16);

      // randomized command traffic, checked cycle by cycle against the model
      for (int n = 0; n < 600; n++) begin
         v = ($urandom_range(0, 2) == 0);
         a = $urandom_range(0, 15);
         case (a)
            3:       d = $urandom_range(0, 12);
            4:       d = $urandom_range(0, 2);
            0, 1, 2: d = $urandom_range(0, 15);
            default: d = $urandom_range(0, 255);
         endcase
         cyc(v, mk(a, d));
      end

      // asynchronous reset in the middle of an active period
      wr(3, 9); wr(4, 0); wr(0, 5); wr(5, 7); wr(6, 0); wr(7, 0);
      repeat (6) cyc(1'b0, 32'h0);
      rst = 1'b1;
      model_reset();
      #1;
      check("rst_pwm", 32'(bus.pwm_out), 32'd0);
      check("rst_ps", 32'(bus.period_start), 32'd0);
      check("rst_err", 32'(bus.cmd_err), 32'd0);
      @(negedge clk);
      cyc(1'b0, 32'h0);
      rst = 1'b0;
      ones = 0;
      for (int j = 0; j < 40; j++) begin
         ones += int'(|bus.pwm_out);
         cyc(1'b0, 32'h0);
      end
      check("post_rst_quiet", 32'(ones), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
